reg_writeback_stage: RTL

MEM/WB pipeline register and writeback driver for the 5-stage pipeline: the write side of the 32x64 register file. It captures the MEM-stage result and selects ALU result or load data. It drives BusW/RW/RegWr into the register file, which commits on the falling edge of the same cycle. It also keeps a one-entry record of the most recently retired write for forwarding, plus a retire counter.

---
 rtl/reg_writeback_stage_if.sv | 65 ++++++
 rtl/reg_writeback_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_writeback_stage_if.sv
// ----------------------------------------------------------------------------
// reg_writeback_stage_if
//
// Bundles the two buses around the writeback stage:
//   - MEM-side capture bus: the MEM/WB pipeline register inputs
//       mem_valid       MEM stage holds a real instruction
//       mem_regwr       instruction writes a register
//       mem_to_reg      1 = write mem_read_data, 0 = write mem_alu_result
//       mem_rd          destination register index
//       mem_alu_result  ALU result
//       mem_read_data   data memory read result
//   - Register-file write port driven by the stage
//       busw            write data
//       rw              write index
//       regwr           write enable (register file commits on falling edge)
//
// Modports:
//   master - producer side (MEM stage / bench): drives the MEM bus and
//            observes the register-file write port.
//   slave  - the writeback stage: consumes the MEM bus and drives the
//            register-file write port.
// ----------------------------------------------------------------------------
interface reg_writeback_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);

  // MEM-side capture bus
  logic                  mem_valid;
  logic                  mem_regwr;
  logic                  mem_to_reg;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_alu_result;
  logic [DATA_WIDTH-1:0] mem_read_data;

  // Register-file write port
  logic [DATA_WIDTH-1:0] busw;
  logic [ADDR_WIDTH-1:0] rw;
  logic                  regwr;

  modport master (
    output mem_valid,
    output mem_regwr,
    output mem_to_reg,
    output mem_rd,
    output mem_alu_result,
    output mem_read_data,
    input  busw,
    input  rw,
    input  regwr
  );

  modport slave (
    input  mem_valid,
    input  mem_regwr,
    input  mem_to_reg,
    input  mem_rd,
    input  mem_alu_result,
    input  mem_read_data,
    output busw,
    output rw,
    output regwr
  );

endinterface : reg_writeback_stage_if

// File: rtl/reg_writeback_stage.sv
// ----------------------------------------------------------------------------
// reg_writeback_stage
//
// MEM/WB pipeline register and writeback driver for the 5-stage pipeline.
// It is the write side of the 32 x DATA_WIDTH register file: the MEM-stage
// result is captured on a rising edge (load data or ALU result selected at
// capture time) and presented as busw/rw/regwr for the remainder of that
// cycle, so the register file commits it on the falling edge in between.
//
// Alongside the write port it keeps:
//   - a one-entry record of the most recently retired register write
//     (fwd_valid/fwd_rd/fwd_data) for the forwarding unit, and
//   - a free-running 32-bit count of retired valid instructions.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset          synchronous, active-high reset
//   stall          hold the WB entry
//   flush          replace the WB entry with a bubble (wins over stall)
//   bus            reg_writeback_stage_if.slave (MEM bus in, RF write port out)
//   wb_valid       WB holds a real instruction
//   fwd_valid      fwd_rd/fwd_data describe the last retired write
//   fwd_rd         last retired destination
//   fwd_data       last retired data
//   retire_count   valid instructions retired, wraps at 2^32
//
// Priority at each rising edge: reset > flush > stall > capture.
// ----------------------------------------------------------------------------
module reg_writeback_stage #(
  parameter int          DATA_WIDTH = 64,
  parameter int          ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  reg_writeback_stage_if.slave     bus,
  output logic                     wb_valid,
  output logic                     fwd_valid,
  output logic [ADDR_WIDTH-1:0]    fwd_rd,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output logic [31:0]              retire_count
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  // Contents of the MEM/WB pipeline register. regwr already has the MEM
  // valid folded in, so a bubble can never request a write.
  typedef struct packed {
    logic                  valid;
    logic                  regwr;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t             wb_q;
  wb_entry_t             wb_capture;

  logic                  fwd_valid_q;
  logic [ADDR_WIDTH-1:0] fwd_rd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [31:0]           retire_count_q;

  logic                  advance;   // WB entry leaves at this edge
  logic                  retire;    // ...and it was a real instruction
  logic                  wr_en;     // entry actually writes the register file

  // --------------------------------------------------------------------------
  // Combinational: capture value, advance/retire qualifiers, write enable.
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wb_capture       = '0;
    wb_capture.valid = bus.mem_valid;
    wb_capture.regwr = bus.mem_valid & bus.mem_regwr;
    wb_capture.rd    = bus.mem_rd;
    wb_capture.data  = bus.mem_to_reg ? bus.mem_read_data : bus.mem_alu_result;
  end

  always_comb begin
    advance = 1'b0;
    retire  = 1'b0;
    wr_en   = 1'b0;

    // Flush pushes the current entry out even when stall is also high.
    advance = flush | ~stall;
    retire  = advance & wb_q.valid;

    // XZR is hard-wired to zero, so a write to it is suppressed here rather
    // than relying on the register file to ignore it.
    wr_en   = wb_q.valid & wb_q.regwr & (wb_q.rd != ZERO_IDX);
  end

  // --------------------------------------------------------------------------
  // Sequential: pipeline register, forwarding record, retire counter.
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering inside the block does
  // not matter (retire/wr_en below see the old wb_q, not the new one).
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q           <= '0;
      fwd_valid_q    <= 1'b0;
      fwd_rd_q       <= '0;
      fwd_data_q     <= '0;
      retire_count_q <= '0;
    end else begin
      // Pipeline register
      if (flush) begin
        wb_q <= '0;
      end else if (!stall) begin
        wb_q <= wb_capture;
      end

      // Forwarding record tracks the entry that leaves WB at this edge.
      // A retiring entry that does not write (e.g. XZR destination, store)
      // invalidates the record but leaves the old rd/data in place.
      if (advance) begin
        if (retire) begin
          retire_count_q <= retire_count_q + 32'd1;
          fwd_valid_q    <= wr_en;
          if (wr_en) begin
            fwd_rd_q   <= wb_q.rd;
            fwd_data_q <= wb_q.data;
          end
        end else begin
          fwd_valid_q <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. A stalled entry keeps regwr high; the register file rewriting
  // the same value on every falling edge is harmless.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.busw     = wb_q.data;
    bus.rw       = wb_q.rd;
    bus.regwr    = wr_en;
    wb_valid     = wb_q.valid;
    fwd_valid    = fwd_valid_q;
    fwd_rd       = fwd_rd_q;
    fwd_data     = fwd_data_q;
    retire_count = retire_count_q;
  end

endmodule : reg_writeback_stage
